// File: rtl/snake_dir_stepper_if.sv
// snake_dir_stepper_if: direction input, run control and head-state outputs of the snake stepper.
interface snake_dir_stepper_if #(
    parameter int X_W = 6,
    parameter int Y_W = 5
);
    logic           run;
    logic [1:0]     dir_in;
    logic [1:0]     cur_dir;
    logic [X_W-1:0] head_x;
    logic [Y_W-1:0] head_y;
    logic           step;
    logic [2:0]     queue_count;
    logic           queue_full;
    logic           wall_hit;
    modport master (
        output run, dir_in,
        input  cur_dir, head_x, head_y, step, queue_count, queue_full, wall_hit
    );
    modport slave (
        input  run, dir_in,
        output cur_dir, head_x, head_y, step, queue_count, queue_full, wall_hit
    );
endinterface

// File: rtl/snake_dir_stepper.sv
// snake_dir_stepper: queues accepted turns and advances the snake head one cell per game tick.
// Define SNAKE_WRAP_EN to wrap at grid edges; otherwise an edge collision latches wall_hit.
module snake_dir_stepper #(
    parameter int GRID_W      = 40,
    parameter int GRID_H      = 30,
    parameter int X_W         = 6,
    parameter int Y_W         = 5,
    parameter int TICK_DIV    = 12500000,
    parameter int QUEUE_DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset,
    snake_dir_stepper_if.slave bus
);
    localparam logic [1:0] LEFT_DIR  = 2'd0;
    localparam logic [1:0] RIGHT_DIR = 2'd1;
    localparam logic [1:0] TOP_DIR   = 2'd2;
    localparam logic [1:0] DOWN_DIR  = 2'd3;
    localparam int CW = $clog2(TICK_DIV);

    logic [1:0]               s1_q, s2_q, prev_q, last_q, cur_q, nd;
    logic [X_W-1:0]           x_q, x_d;
    logic [Y_W-1:0]           y_q, y_d;
    logic [CW-1:0]            cnt_q;
    logic [2*QUEUE_DEPTH-1:0] q_q, q_d;
    logic [2:0]               count_q, count_d, widx;
    logic                     step_q, wall_q, full, push, pop, tick;

    assign full = count_q == 3'(QUEUE_DEPTH);
    // XOR of two codes is 0 for equal and 1 for opposite directions with this encoding
    assign push = (s2_q != prev_q) && !full && ((s2_q ^ last_q) > 2'd1);
    assign tick = bus.run && cnt_q == CW'(TICK_DIV - 1) && !wall_q;
    assign pop = tick && count_q != 3'd0;
    assign nd = pop ? q_q[1:0] : cur_q;
    assign widx = count_q - 3'(pop);
    assign count_d = count_q + 3'(push) - 3'(pop);

    always_comb begin
        q_d = pop ? q_q >> 2 : q_q;
        if (push) q_d[{widx, 1'b0} +: 2] = s2_q;
    end

    assign x_d = nd == LEFT_DIR  ? (x_q == '0 ? X_W'(GRID_W - 1) : x_q - X_W'(1)) :
                 nd == RIGHT_DIR ? (x_q == X_W'(GRID_W - 1) ? '0 : x_q + X_W'(1)) : x_q;
    assign y_d = nd == TOP_DIR   ? (y_q == '0 ? Y_W'(GRID_H - 1) : y_q - Y_W'(1)) :
                 nd == DOWN_DIR  ? (y_q == Y_W'(GRID_H - 1) ? '0 : y_q + Y_W'(1)) : y_q;

`ifndef SNAKE_WRAP_EN
    logic at_edge;
    assign at_edge = (nd == LEFT_DIR && x_q == '0) || (nd == RIGHT_DIR && x_q == X_W'(GRID_W - 1)) ||
                     (nd == TOP_DIR && y_q == '0) || (nd == DOWN_DIR && y_q == Y_W'(GRID_H - 1));
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q    <= TOP_DIR;
            s2_q    <= TOP_DIR;
            prev_q  <= TOP_DIR;
            last_q  <= TOP_DIR;
            cur_q   <= TOP_DIR;
            x_q     <= X_W'(GRID_W / 2);
            y_q     <= Y_W'(GRID_H / 2);
            cnt_q   <= '0;
            q_q     <= '0;
            count_q <= '0;
            step_q  <= 1'b0;
            wall_q  <= 1'b0;
        end else begin
            s1_q    <= bus.dir_in;
            s2_q    <= s1_q;
            prev_q  <= s2_q;
            q_q     <= q_d;
            count_q <= count_d;
            step_q  <= tick;
            if (push) last_q <= s2_q;
            if (bus.run) cnt_q <= cnt_q == CW'(TICK_DIV - 1) ? '0 : cnt_q + CW'(1);
            if (tick) begin
                cur_q <= nd;
`ifdef SNAKE_WRAP_EN
                x_q <= x_d;
                y_q <= y_d;
`else
                if (at_edge) begin
                    wall_q <= 1'b1;
                end else begin
                    x_q <= x_d;
                    y_q <= y_d;
                end
`endif
            end
        end
    end

    assign bus.cur_dir     = cur_q;
    assign bus.head_x      = x_q;
    assign bus.head_y      = y_q;
    assign bus.step        = step_q;
    assign bus.queue_count = count_q;
    assign bus.queue_full  = full;
    assign bus.wall_hit    = wall_q;
endmodule

// File: tb/tb_snake_dir_stepper.sv
// tb_snake_dir_stepper: directed and random stimulus against a queue-based reference of the head stepper.
module tb_snake_dir_stepper;
    localparam int GW = 40, GH = 30, XW = 6, YW = 5, TD = 4, QD = 2;
    localparam logic [1:0] LEFT = 2'd0, RIGHT = 2'd1, TOP = 2'd2, DOWN = 2'd3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    snake_dir_stepper_if #(.X_W(XW), .Y_W(YW)) bus ();
    snake_dir_stepper #(
        .GRID_W(GW), .GRID_H(GH), .X_W(XW), .Y_W(YW), .TICK_DIV(TD), .QUEUE_DEPTH(QD)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int checks = 0, errors = 0;
    int m_x, m_y, m_cnt;
    logic [1:0] m_s1, m_s2, m_prev, m_last, m_cur;
    logic m_step, m_wall;
    logic [1:0] m_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    function automatic logic [1:0] opposite(input logic [1:0] d);
        case (d)
            LEFT:    return RIGHT;
            RIGHT:   return LEFT;
            TOP:     return DOWN;
            default: return TOP;
        endcase
    endfunction

    task automatic model_step();
        int nx, ny;
        logic accept, tick;
        if (reset) begin
            m_x = GW / 2; m_y = GH / 2; m_cnt = 0;
            m_s1 = TOP; m_s2 = TOP; m_prev = TOP; m_last = TOP; m_cur = TOP;
            m_step = 0; m_wall = 0; m_q.delete();
            return;
        end
        accept = (m_s2 != m_prev) && (m_q.size() < QD) && (m_s2 != m_last) && (m_s2 != opposite(m_last));
        tick = bus.run && (m_cnt == TD - 1) && !m_wall;
        m_step = tick;
        if (tick) begin
            if (m_q.size() > 0) m_cur = m_q.pop_front();
            nx = m_x + (m_cur == LEFT ? -1 : m_cur == RIGHT ? 1 : 0);
            ny = m_y + (m_cur == TOP ? -1 : m_cur == DOWN ? 1 : 0);
`ifdef SNAKE_WRAP_EN
            m_x = (nx + GW) % GW;
            m_y = (ny + GH) % GH;
`else
            if (nx < 0 || nx >= GW || ny < 0 || ny >= GH) m_wall = 1;
            else begin m_x = nx; m_y = ny; end
`endif
        end
        if (accept) begin
            m_q.push_back(m_s2);
            m_last = m_s2;
        end
        if (bus.run) m_cnt = (m_cnt + 1) % TD;
        m_prev = m_s2;
        m_s2 = m_s1;
        m_s1 = bus.dir_in;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        chk("head_x", 32'(bus.head_x), m_x);
        chk("head_y", 32'(bus.head_y), m_y);
        chk("cur_dir", 32'(bus.cur_dir), 32'(m_cur));
        chk("step", 32'(bus.step), 32'(m_step));
        chk("queue_count", 32'(bus.queue_count), m_q.size());
        chk("queue_full", 32'(bus.queue_full), 32'(m_q.size() == QD));
        chk("wall_hit", 32'(bus.wall_hit), 32'(m_wall));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        bus.run = 1'b0;
        bus.dir_in = TOP;
        do_reset();
        cyc();
        bus.run = 1'b1;
        repeat (12) cyc();
        bus.dir_in = DOWN;
        repeat (8) cyc();
        bus.dir_in = LEFT;  cyc();
        bus.dir_in = DOWN;  cyc();
        bus.dir_in = RIGHT; cyc();
        repeat (12) cyc();
        for (int ph = 0; ph < TD; ph++) begin
            bus.dir_in = TOP;
            do_reset();
            bus.run = 1'b1;
            bus.dir_in = LEFT;
            repeat (ph + 1) cyc();
            bus.dir_in = DOWN;
            repeat (12) cyc();
        end
        bus.dir_in = TOP;
        do_reset();
        bus.run = 1'b1;
        bus.dir_in = LEFT;
        repeat (TD * 22 + 12) cyc();
        bus.dir_in = TOP;
        do_reset();
        bus.run = 1'b0;
        bus.dir_in = LEFT; repeat (2) cyc();
        bus.dir_in = DOWN; repeat (4) cyc();
        bus.run = 1'b1;
        repeat (2) cyc();
        do_reset();
        repeat (6) cyc();
        for (int seg = 0; seg < 20; seg++) begin
            bus.dir_in = TOP;
            do_reset();
            bus.run = 1'b1;
            repeat (150) begin
                if ($urandom_range(0, 2) == 0) bus.dir_in = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 15) == 0) bus.run = ~bus.run;
                reset = ($urandom_range(0, 199) == 0);
                cyc();
            end
            reset = 1'b0;
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
